// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson counter decoder.
// Holds the FSM state type, the legal code table and the code width.
package johnson_pkg;

  localparam int CODE_W = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } jstate_t;

  // Legal Johnson codes, entry i is the code for index i.
  localparam logic [7:0][CODE_W-1:0] LEGAL_CODES = {
    4'b1000, 4'b1100, 4'b1110, 4'b1111,
    4'b0111, 4'b0011, 4'b0001, 4'b0000
  };

  function automatic logic [7:0] idx2oh(input logic [2:0] i);
    return 8'b1 << i;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational map from a 4-bit code to {legal, index}.
// Illegal codes report index 0 with legal low.
module johnson_code_decode
  import johnson_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic              legal,
  output logic [2:0]        index
);

  // Table lookup against the eight legal codes.
  always_comb begin
    legal = 1'b0;
    index = '0;
    for (int i = 0; i < 8; i++) begin
      if (code == LEGAL_CODES[i]) begin
        legal = 1'b1;
        index = 3'(i);
      end
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter decoder with lock tracking and error counters.
// Locks after LOCK_N in-order samples, unlocks after UNLOCK_N violations.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 2
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [CODE_W-1:0] count_in,
  input  logic              valid_in,
  input  logic              clear,
  output logic [2:0]        state_idx,
  output logic [7:0]        onehot,
  output logic              locked,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [7:0]        wrap_cnt
);

  localparam int RUN_MAX = (LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N;
  localparam int RUN_W   = $clog2(RUN_MAX) + 1;

  logic             legal;
  logic [2:0]       idx;
  logic [2:0]       nxt_idx;
  logic             seq_ok;
  logic             in_order;
  logic             held;
  jstate_t          st;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] vrun;
  logic [RUN_W-1:0] hunt_run;
  logic [RUN_W-1:0] vrun_inc;

  johnson_code_decode u_dec (
    .code  (count_in),
    .legal (legal),
    .index (idx)
  );

  assign nxt_idx  = state_idx + 3'd1;
  assign seq_ok   = legal && held && (idx == nxt_idx);
  assign in_order = valid_in && seq_ok;
  assign hunt_run = seq_ok ? run + 1'b1 : RUN_W'(1);
  assign vrun_inc = vrun + 1'b1;

  // Lock FSM, anchor index, one-hot view and the err pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      st        <= HUNT;
      state_idx <= '0;
      onehot    <= '0;
      held      <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      run       <= '0;
      vrun      <= '0;
    end else begin
      err <= 1'b0;
      if (valid_in) begin
        unique case (st)
          HUNT: begin
            if (legal) begin
              state_idx <= idx;
              onehot    <= idx2oh(idx);
              held      <= 1'b1;
              if (hunt_run >= RUN_W'(LOCK_N)) begin
                st     <= LOCKED;
                locked <= 1'b1;
                run    <= '0;
                vrun   <= '0;
              end else begin
                run <= hunt_run;
              end
            end else begin
              run    <= '0;
              held   <= 1'b0;
              onehot <= '0;
            end
          end
          LOCKED: begin
            if (seq_ok) begin
              state_idx <= idx;
              onehot    <= idx2oh(idx);
              vrun      <= '0;
            end else begin
              err <= 1'b1;
              if (legal) begin
                state_idx <= idx;
                onehot    <= idx2oh(idx);
              end
              if (vrun_inc >= RUN_W'(UNLOCK_N)) begin
                st     <= HUNT;
                locked <= 1'b0;
                run    <= '0;
                vrun   <= '0;
              end else begin
                vrun <= vrun_inc;
              end
            end
          end
        endcase
      end
    end
  end

  // Violation and wrap counters; clear wins over any increment.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else if (clear) begin
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else if (valid_in && st == LOCKED) begin
      if (!seq_ok && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (in_order && state_idx == 3'd7)
        wrap_cnt <= wrap_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed scoreboard bench for johnson_decoder.
// Expected outputs are queued at drive time and checked after the edge.
module tb_johnson_decoder;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count_in = 4'h0;
  logic       valid_in = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] state_idx;
  logic [7:0] onehot;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] oh;
    logic       lk;
    logic       er;
    logic [7:0] ec;
    logic [7:0] wc;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] codes[8];
  int         k;
  int         ec;
  int         wc;

  johnson_decoder dut (
    .clock     (clock),
    .rst       (rst),
    .count_in  (count_in),
    .valid_in  (valid_in),
    .clear     (clear),
    .state_idx (state_idx),
    .onehot    (onehot),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .wrap_cnt  (wrap_cnt)
  );

  always #5 clock = ~clock;

  task automatic push(input logic [2:0] i, input logic h,
                      input logic l, input logic e,
                      input logic [7:0] c, input logic [7:0] w);
    exp_t x;
    x.idx = i;
    x.oh  = h ? (8'b1 << i) : 8'h00;
    x.lk  = l;
    x.er  = e;
    x.ec  = c;
    x.wc  = w;
    sb.push_back(x);
  endtask

  task automatic chk1(input string tag, input logic [7:0] got,
                      input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty got=0 want=1", tag);
    end else begin
      x = sb.pop_front();
      chk1({tag, ".idx"}, 8'(state_idx), 8'(x.idx));
      chk1({tag, ".oh"}, onehot, x.oh);
      chk1({tag, ".lk"}, 8'(locked), 8'(x.lk));
      chk1({tag, ".err"}, 8'(err), 8'(x.er));
      chk1({tag, ".ec"}, err_cnt, x.ec);
      chk1({tag, ".wc"}, wrap_cnt, x.wc);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] c,
                      input logic v, input logic clr,
                      input logic [2:0] i, input logic h,
                      input logic l, input logic e,
                      input logic [7:0] xc, input logic [7:0] xw);
    @(negedge clock);
    count_in = c;
    valid_in = v;
    clear    = clr;
    push(i, h, l, e, xc, xw);
    @(posedge clock);
    #1;
    check_out(tag);
  endtask

  initial begin
    codes = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    repeat (2) @(posedge clock);
    #1;
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check_out("reset");
    @(negedge clock);
    rst = 1'b1;

    step("idle", 4'h1, 0, 0, 3'd0, 0, 0, 0, 8'd0, 8'd0);
    step("s0", 4'h0, 1, 0, 3'd0, 1, 0, 0, 8'd0, 8'd0);
    step("s1", 4'h1, 1, 0, 3'd1, 1, 0, 0, 8'd0, 8'd0);
    step("lock", 4'h3, 1, 0, 3'd2, 1, 1, 0, 8'd0, 8'd0);
    step("hold", 4'h5, 0, 0, 3'd2, 1, 1, 0, 8'd0, 8'd0);

    k  = 2;
    wc = 0;
    for (int n = 0; n < 9; n++) begin
      k = (k + 1) % 8;
      if (k == 0) wc++;
      step("run", codes[k], 1, 0, 3'(k), 1, 1, 0, 8'd0, 8'(wc));
    end

    step("inj", 4'h5, 1, 0, 3'd3, 1, 1, 1, 8'd1, 8'd1);
    step("resume", 4'hF, 1, 0, 3'd4, 1, 1, 0, 8'd1, 8'd1);
    step("repeat", 4'hF, 1, 0, 3'd4, 1, 1, 1, 8'd2, 8'd1);
    step("skip", 4'hC, 1, 0, 3'd6, 1, 0, 1, 8'd3, 8'd1);
    step("h7", 4'h8, 1, 0, 3'd7, 1, 0, 0, 8'd3, 8'd1);
    step("h0", 4'h0, 1, 0, 3'd0, 1, 0, 0, 8'd3, 8'd1);
    step("relock", 4'h1, 1, 0, 3'd1, 1, 1, 0, 8'd3, 8'd1);

    step("clr", 4'h0, 0, 1, 3'd1, 1, 1, 0, 8'd0, 8'd0);
    step("ill1", 4'h2, 1, 0, 3'd1, 1, 1, 1, 8'd1, 8'd0);
    step("ill2", 4'hB, 1, 0, 3'd1, 1, 0, 1, 8'd2, 8'd0);
    step("hill", 4'h5, 1, 0, 3'd1, 0, 0, 0, 8'd2, 8'd0);
    step("r2", 4'h3, 1, 0, 3'd2, 1, 0, 0, 8'd2, 8'd0);
    step("r3", 4'h7, 1, 0, 3'd3, 1, 0, 0, 8'd2, 8'd0);
    step("r4", 4'hF, 1, 0, 3'd4, 1, 1, 0, 8'd2, 8'd0);

    k  = 4;
    ec = 2;
    wc = 0;
    for (int n = 0; n < 253; n++) begin
      ec = (ec < 255) ? ec + 1 : 255;
      step("sat_v", 4'h5, 1, 0, 3'(k), 1, 1, 1, 8'(ec), 8'(wc));
      k = (k + 1) % 8;
      if (k == 0) wc = (wc + 1) % 256;
      step("sat_o", codes[k], 1, 0, 3'(k), 1, 1, 0, 8'(ec), 8'(wc));
    end
    step("sat_hold", 4'h5, 1, 0, 3'(k), 1, 1, 1, 8'd255, 8'(wc));
    k = (k + 1) % 8;
    if (k == 0) wc = (wc + 1) % 256;
    step("sat_o2", codes[k], 1, 0, 3'(k), 1, 1, 0, 8'd255, 8'(wc));
    step("clr_v", 4'h5, 1, 1, 3'(k), 1, 1, 1, 8'd0, 8'd0);
    wc = 0;
    k  = (k + 1) % 8;
    if (k == 0) wc = 1;
    step("post_clr", codes[k], 1, 0, 3'(k), 1, 1, 0, 8'd0, 8'(wc));

    @(posedge clock);
    #3;
    rst = 1'b0;
    #1;
    push(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    check_out("async_rst");
    @(negedge clock);
    valid_in = 1'b0;
    rst      = 1'b1;

    step("a6", 4'hC, 1, 0, 3'd6, 1, 0, 0, 8'd0, 8'd0);
    step("a7", 4'h8, 1, 0, 3'd7, 1, 0, 0, 8'd0, 8'd0);
    step("a0", 4'h0, 1, 0, 3'd0, 1, 1, 0, 8'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter LOCK_N, default 3: consecutive legal in-order samples needed to enter LOCKED.
REQ-002 Parameter UNLOCK_N, default 2: consecutive violations in LOCKED needed to return to HUNT.
REQ-003 Port clock, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port count_in, input, 4: Johnson code sampled from the counter under observation.
REQ-006 Port valid_in, input, 1: count_in is sampled only when this is high.
REQ-007 Port clear, input, 1: synchronous clear of err_cnt and wrap_cnt.
REQ-008 Port state_idx, output, 3: decoded index 0-7 of the last legal sample.
REQ-009 Port onehot, output, 8: one-hot form of state_idx; all zeros when no legal sample is held.
REQ-010 Port locked, output, 1: high in LOCKED.
REQ-011 Port err, output, 1: one-cycle pulse per violation while LOCKED.
REQ-012 Port err_cnt, output, 8: violation count, saturating at 255.
REQ-013 Port wrap_cnt, output, 8: full-cycle count, modulo 256.

Function
REQ-014 Legal sequence, index 0-7: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
REQ-015 The other 8 codes are illegal (e.g. 0101, 0010, 1011).
REQ-016 All outputs are registered, with 1-cycle latency from a valid_in sample to the output update.
REQ-017 valid_in low: all state and outputs hold, and err is low.
REQ-018 A sample is in-order when it is legal and its index equals (previous legal index + 1) mod 8.
REQ-019 A sample is a violation when it is illegal, is a repeated code, or is a skipped legal code.
REQ-020 FSM states are HUNT and LOCKED; the reset state is HUNT.
REQ-021 HUNT, behaviour: any legal sample loads state_idx, and the in-order run counter increments on in-order samples.
REQ-022 HUNT, on a non-in-order legal sample: the run counter is set to 1.
REQ-023 HUNT, on an illegal sample: the run counter and onehot are zeroed.
REQ-024 HUNT to LOCKED: the run counter reaches LOCK_N; locked rises in the same cycle as that sample's outputs.
REQ-025 LOCKED, behaviour: an in-order sample updates state_idx and clears the violation run.
REQ-026 LOCKED, on a violation: err pulses, err_cnt increments, the violation run increments, and state_idx re-anchors if the sample is legal.
REQ-027 LOCKED to HUNT: the violation run reaches UNLOCK_N, with the run counters cleared; the err pulse of that sample is still issued.
REQ-028 err is never asserted in HUNT, and err_cnt does not change in HUNT.
REQ-029 wrap_cnt increments on each in-order 7-to-0 transition while LOCKED, and wraps from 255 to 0.
REQ-030 err_cnt holds at 255 once reached.
REQ-031 clear high zeroes err_cnt and wrap_cnt next cycle, and takes priority over a simultaneous increment.
REQ-032 clear does not affect the FSM, state_idx or err.

Reset
REQ-033 rst low immediately forces: FSM to HUNT, state_idx to 0, onehot to 0, locked to 0, err to 0, err_cnt to 0, wrap_cnt to 0, and all internal run counters to 0.
REQ-034 Reset asserted mid-LOCKED discards the anchor, so relock requires LOCK_N fresh in-order samples.
REQ-035 The first edge after rst rises treats the block as having no previous sample.

Structure
REQ-036 Shared package johnson_pkg holds the FSM state typedef, the 8-entry legal code table, and the code width constant 4.
REQ-037 One combinational sub-module, johnson_code_decode, maps count_in to {legal, index}.
REQ-038 Run counters are sized as clog2 of max(LOCK_N, UNLOCK_N) plus 1.

Verification
REQ-039 Scenario: reset, then a valid_in stream 0000, 0001, 0011. Required: locked rises 1 cycle after the 0011 sample, with state_idx=2 and onehot=00000100.
REQ-040 Scenario: locked, then 9 in-order samples crossing 1000 to 0000. Required: wrap_cnt=1, err never high.
REQ-041 Scenario: locked at index 3, inject 0101, then resume with 1111. Required: one err pulse, err_cnt=1, locked stays high.
REQ-042 Scenario: locked, two consecutive illegal samples. Required: 2 err pulses, locked low after the second, err_cnt=2.
REQ-043 Scenario: err_cnt at 255 plus one more violation, then clear and a violation in the same cycle. Required: err_cnt stays 255, then reads 0.
REQ-044 Scenario: rst pulsed low mid-LOCKED between clock edges. Required: outputs zero immediately, and locked only after 3 new in-order samples.
